// File: rtl/rr_mux_nto1_pkg.sv
// rtl/rr_mux_nto1_pkg.sv - shared sizing helpers and defaults for the round-robin mux
package mux_pkg;

    localparam int DEF_N     = 4;
    localparam int DEF_WIDTH = 8;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int ch_w(input int n);
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

    typedef logic [ch_w(DEF_N)-1:0] ch_idx_t;

endpackage

// File: rtl/rr_mux_nto1_if.sv
// rtl/rr_mux_nto1_if.sv - N producer streams in, one tagged consumer stream out
interface rr_mux_nto1_if
    import mux_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WIDTH = DEF_WIDTH,
    parameter int CH_W  = ch_w(N)
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [CH_W-1:0]    out_ch;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/rr_mux_nto1_grant.sv
// rtl/rr_mux_nto1_grant.sv - combinational round-robin search starting at ptr
module rr_grant
    import mux_pkg::*;
#(
    parameter int N    = DEF_N,
    parameter int CH_W = ch_w(N)
) (
    input  logic [N-1:0]    valid,
    input  logic [CH_W-1:0] ptr,
    output logic [N-1:0]    grant_oh,
    output logic [CH_W-1:0] grant_idx,
    output logic            any_grant
);

    always_comb begin
        int idx;
        grant_oh  = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        // Modulo keeps non-power-of-two N wrapping from N-1 back to 0.
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any_grant && valid[idx]) begin
                any_grant     = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_mux_nto1.sv
// rtl/rr_mux_nto1.sv - registered round-robin N:1 mux; optional RR_MUX_FORCE_SEL_EN forced grant
module rr_mux_nto1
    import mux_pkg::*;
#(
    parameter int  N     = DEF_N,
    parameter int  WIDTH = DEF_WIDTH,
    localparam int CH_W  = ch_w(N)
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef RR_MUX_FORCE_SEL_EN
    input  logic            force_en,
    input  logic [CH_W-1:0] force_sel,
`endif
    rr_mux_nto1_if.slave    bus
);

    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  next_ptr;
    logic [CH_W-1:0]  grant_idx;
    logic [CH_W-1:0]  out_ch_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;
    logic [N-1:0]     req;
    logic [N-1:0]     grant_oh;
    logic             any_grant;
    logic             accept;
    logic             xfer;
    logic             forced;

`ifdef RR_MUX_FORCE_SEL_EN
    // Masking requests down to the forced channel lets the normal search pick it.
    always_comb begin
        req    = bus.in_valid;
        forced = force_en;
        if (force_en) begin
            for (int i = 0; i < N; i++) begin
                req[i] = bus.in_valid[i] && (int'(force_sel) == i);
            end
        end
    end
`else
    assign req    = bus.in_valid;
    assign forced = 1'b0;
`endif

    rr_grant #(.N(N), .CH_W(CH_W)) u_grant (
        .valid     (req),
        .ptr       (rr_ptr),
        .grant_oh  (grant_oh),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign accept       = !out_valid_q || bus.out_ready;
    assign xfer         = accept && any_grant;
    assign bus.in_ready = accept ? grant_oh : '0;
    assign next_ptr     = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr      <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
            out_ch_q    <= grant_idx;
            if (!forced) begin
                rr_ptr <= next_ptr;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: doc/rr_mux_nto1.md
Name: rr_mux_nto1

Overview:
- Parametrised N-channel, WIDTH-bit registered multiplexer with per-channel valid/ready handshake.
- Selection is made by a round-robin arbiter, not by an external select.
- Sits in front of shared datapath resources: merges N producer streams into one consumer stream at up to one word per cycle.
- One register stage on the output; the result carries the index of the channel that supplied it.

Parameters:
- N, 4, number of input channels (N >= 1).
- WIDTH, 8, data width per channel.
- CH_W, max(1, clog2(N)), width of the channel index; derived, not overridden.

Ports:
- clk  in  1  sole clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready; at most one bit high in any cycle.
- out_data  out  WIDTH  registered selected word.
- out_ch  out  CH_W  index of the channel that supplied out_data.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer ready.

Behaviour:
- Reset (async assert, sync deassert is handled upstream): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. Reset asserted mid-transfer discards the held word with no output handshake.
- accept = !out_valid || out_ready. The stage loads when it is empty or being drained in the same cycle. This gives full throughput with no bubble.
- Grant (combinational): g is the first channel with in_valid high, searching rr_ptr, rr_ptr+1, ..., N-1, then 0, ..., rr_ptr-1. If no channel is valid, there is no grant.
- in_ready[i] = accept && grant && (g == i). in_ready depends combinationally on out_ready and in_valid. in_valid must not depend on in_ready.
- Transfer on channel g (in_valid[g] && in_ready[g]) loads the following on the next edge:
  - out_data <= channel g data
  - out_ch <= g
  - out_valid <= 1
  - rr_ptr <= (g+1) mod N
- Latency: 1 cycle from input handshake to out_valid.
- Output drain only (out_valid && out_ready, and no valid input): out_valid <= 0. out_data and out_ch hold their last values.
- Backpressure (out_valid && !out_ready): all in_ready=0. Output is held stable. rr_ptr is unchanged, so the grant is re-evaluated each cycle and fairness is preserved.
- Producers hold data and valid until ready. Dropping valid before a grant is legal; the arbiter simply skips that channel.
- Wrap-around: the search wraps modulo N. With N not a power of two, index N-1 wraps to 0, never to N.
- N=1: the grant is always channel 0, rr_ptr is stuck at 0, and out_ch is 1 bit and reads 0.

Optional Feature:
- Macro: RR_MUX_FORCE_SEL_EN.
- With the macro defined:
  - Extra inputs force_en (1) and force_sel (CH_W) are added.
  - While force_en=1, the grant is force_sel only, qualified by in_valid[force_sel]. If force_sel >= N or the channel is idle, there is no grant.
  - A forced transfer leaves rr_ptr unchanged.
- Without the macro: the ports are absent and the block is pure round-robin.

Decomposition:
- Package mux_pkg:
  - clog2-based CH_W helper function.
  - Default WIDTH/N localparams.
  - typedef for the channel index.
- Sub-module rr_grant: combinational, N-bit in_valid plus rr_ptr in, one-hot grant plus encoded index plus any_grant out.
- The top level holds the output register, rr_ptr, and the force logic.

Test Plan:
- Reset: drive rst_n=0 while out_valid=1 holding 0x3C -> out_valid=0, out_data=0 and out_ch=0 immediately (asynchronous); first grant after release is from rr_ptr=0.
- Single channel: in_valid=4'b0100, ch2 data 0xA5, out_ready=1 -> in_ready=4'b0100 that cycle; next cycle out_valid=1, out_data=0xA5, out_ch=2.
- Fairness: all four channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 with one word per cycle and no bubbles.
- Backpressure: out_ready=0 for 5 cycles with all channels valid -> in_ready=0, out_data/out_ch stable; on release, the next grant goes to rr_ptr's channel and no word is lost or duplicated.
- Wrap: after a grant to ch2 (rr_ptr=3), in_valid=4'b0011 -> grants ch0 then ch1; then N=3 build, grant ch2 -> rr_ptr=0.
- Force (macro on): force_en=1, force_sel=1, in_valid=4'b1011 -> only ch1 transfers; rr_ptr unchanged. force_sel=2 with ch2 idle -> no transfer, out_valid drains to 0.
